// File: rtl/bus_initiator_pkg.sv
// rtl/bus_initiator_pkg.sv - shared encodings for the bus initiator
// Purpose: state encodings, transfer direction, active-low level names,
//          reset level and default word bus widths.
// Ports:   none (package).
package bus_initiator_pkg;

    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'h0,
        ST_REQ    = 2'h1,
        ST_ACCESS = 2'h2
    } state_e;

    localparam logic READ         = 1'b1;
    localparam logic WRITE        = 1'b0;
    localparam logic ENABLE_      = 1'b0;
    localparam logic DISABLE_     = 1'b1;
    localparam logic RESET_ENABLE = 1'b0;

endpackage

// File: rtl/bus_timeout_cnt.sv
// rtl/bus_timeout_cnt.sv - ready-wait watchdog counter
// Purpose: counts stalled ACCESS cycles; flags expiry on the TIMEOUT-th one.
// Ports:   clk_i, resetn_i (sync active-low), clr_i (restart at 0),
//          en_i (count this cycle), expired_o (current cycle is the last allowed).
module bus_timeout_cnt
    import bus_initiator_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count value k means k stalled cycles already elapsed, so the cycle in
    // which the count equals TIMEOUT-1 is the TIMEOUT-th one.
    assign expired_o = (cnt_q >= LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (resetn_i == RESET_ENABLE) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_initiator.sv
// rtl/bus_initiator.sv - single-word bus master for the CS/AS/ready bus
// Purpose: takes one read/write from the core client, requests the bus,
//          issues a one-cycle address strobe, waits for active-low ready and
//          returns data plus a completion pulse. Optional ready watchdog when
//          BUS_TIMEOUT_EN is defined.
// Ports:   clk, reset (sync active-low)
//          client: cpu_req, cpu_rw, cpu_addr, cpu_wr_data -> cpu_busy,
//                  cpu_done, cpu_rd_data, cpu_err
//          bus:    bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data out;
//                  bus_grnt_, bus_rd_data, bus_rdy_ in
module bus_initiator
    import bus_initiator_pkg::*;
#(
    parameter int ADDR_W  = WORD_ADDR_W,
    parameter int DATA_W  = WORD_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              cpu_err,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_
);

    state_e            state_q, state_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_as_q, bus_as_d;
    logic              bus_rw_q, bus_rw_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wr_data_q, bus_wr_data_d;
    logic              cpu_done_q, cpu_done_d;
    logic              cpu_err_q, cpu_err_d;
    logic [DATA_W-1:0] cpu_rd_data_q, cpu_rd_data_d;

    logic rdy_hit;
    logic timeout_hit;

    // The first ACCESS cycle is the strobe cycle; a responder cannot have
    // answered yet, so ready is only honoured once the strobe is gone.
    assign rdy_hit = (state_q == ST_ACCESS) && (bus_as_q == DISABLE_) && (bus_rdy_ == ENABLE_);

`ifdef BUS_TIMEOUT_EN
    logic cnt_clr;
    logic cnt_en;
    logic cnt_expired;

    assign cnt_clr = (state_q == ST_REQ) && (bus_grnt_ == ENABLE_);
    assign cnt_en  = (state_q == ST_ACCESS) && (bus_rdy_ == DISABLE_);

    bus_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk_i     (clk),
        .resetn_i  (reset),
        .clr_i     (cnt_clr),
        .en_i      (cnt_en),
        .expired_o (cnt_expired)
    );

    assign timeout_hit = (state_q == ST_ACCESS) && cnt_expired;
`else
    // Without the watchdog ACCESS waits forever; TIMEOUT has no effect.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT != 0);
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        rw_d          = rw_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        bus_req_d     = bus_req_q;
        // Bus lines are OR-muxed, so they idle at zero outside the strobe.
        bus_as_d      = DISABLE_;
        bus_rw_d      = 1'b0;
        bus_addr_d    = '0;
        bus_wr_data_d = '0;
        cpu_done_d    = 1'b0;
        cpu_err_d     = 1'b0;
        cpu_rd_data_d = cpu_rd_data_q;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    rw_d      = cpu_rw;
                    addr_d    = cpu_addr;
                    wdata_d   = cpu_wr_data;
                    bus_req_d = ENABLE_;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                bus_req_d = ENABLE_;
                if (bus_grnt_ == ENABLE_) begin
                    bus_as_d      = ENABLE_;
                    bus_rw_d      = rw_q;
                    bus_addr_d    = addr_q;
                    bus_wr_data_d = wdata_q;
                    state_d       = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (rdy_hit) begin
                    if (rw_q == READ) begin
                        cpu_rd_data_d = bus_rd_data;
                    end
                    cpu_done_d = 1'b1;
                    bus_req_d  = DISABLE_;
                    state_d    = ST_IDLE;
                end else if (timeout_hit) begin
                    cpu_done_d    = 1'b1;
                    cpu_err_d     = 1'b1;
                    cpu_rd_data_d = '0;
                    bus_req_d     = DISABLE_;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset == RESET_ENABLE) begin
            state_q       <= ST_IDLE;
            rw_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            bus_req_q     <= DISABLE_;
            bus_as_q      <= DISABLE_;
            bus_rw_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wr_data_q <= '0;
            cpu_done_q    <= 1'b0;
            cpu_err_q     <= 1'b0;
            cpu_rd_data_q <= '0;
        end else begin
            state_q       <= state_d;
            rw_q          <= rw_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            bus_req_q     <= bus_req_d;
            bus_as_q      <= bus_as_d;
            bus_rw_q      <= bus_rw_d;
            bus_addr_q    <= bus_addr_d;
            bus_wr_data_q <= bus_wr_data_d;
            cpu_done_q    <= cpu_done_d;
            cpu_err_q     <= cpu_err_d;
            cpu_rd_data_q <= cpu_rd_data_d;
        end
    end

    assign cpu_busy    = (state_q != ST_IDLE);
    assign cpu_done    = cpu_done_q;
    assign cpu_err     = cpu_err_q;
    assign cpu_rd_data = cpu_rd_data_q;
    assign bus_req_    = bus_req_q;
    assign bus_as_     = bus_as_q;
    assign bus_rw      = bus_rw_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wr_data = bus_wr_data_q;

endmodule
